regfile_writeback: RTL

- Write-side driver for the 32x32 register file: merges the in-order pipeline writeback stream with out-of-order multiply/divide results and drives the regfile's single write port.
- Multiply/divide results wait in a small squashable FIFO.
- Exports a busy mask of pending registers and forwarding data for the regfile's two read addresses.
- Sits between the W stage / multdiv unit and the register file.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_md_fifo.sv | 115 +++++++++++
 rtl/regfile_writeback.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the 32x32 register file write side.
//   DATA_W   : register data width
//   REG_W    : register index width
//   NUM_REGS : number of architectural registers (width of busy masks)
//   ZERO_REG : hard-wired zero register, never written
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/wb_md_fifo.sv
// ---------------------------------------------------------------------------
// wb_md_fifo
// Squashable, order-preserving queue for multiply/divide results waiting for
// the register file write port.
//
// Valid entries are always kept packed at the low indices, so entry 0 is the
// oldest. When a squash invalidates an entry, the entry is freed on that same
// edge and the younger entries close the gap. A squashed entry therefore never
// reaches the head, never causes a write, and never holds a slot. This
// guarantees a free slot whenever the valid count is below DEPTH.
//
// Ports
//   clock, ctrl_reset      : clock, synchronous active-low reset
//   pushEn/pushReg/pushData: enqueue a result (caller ensures validCount < DEPTH)
//   popEn                  : retire the head entry (caller ensures headValid)
//   squashEn/squashReg     : invalidate every queued entry targeting squashReg;
//                            the entry pushed on the same edge is younger and
//                            is not affected
//   headValid/Reg/Data     : oldest queued entry
//   validCount             : number of valid entries
//   busyMask               : one-hot OR of the target registers of valid entries
// ---------------------------------------------------------------------------
module wb_md_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int REG_W  = regfile_pkg::REG_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                pushEn,
  input  logic [REG_W-1:0]    pushReg,
  input  logic [DATA_W-1:0]   pushData,
  input  logic                popEn,
  input  logic                squashEn,
  input  logic [REG_W-1:0]    squashReg,
  output logic                headValid,
  output logic [REG_W-1:0]    headReg,
  output logic [DATA_W-1:0]   headData,
  output logic [CNT_W-1:0]    validCount,
  output logic [NUM_REGS-1:0] busyMask
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  regIdx;
    logic [DATA_W-1:0] data;
  } mdEntry_t;

  mdEntry_t         entries     [DEPTH];
  mdEntry_t         nextEntries [DEPTH];
  logic [CNT_W-1:0] wrPos;
  logic             keepEntry;

  // Rebuild the queue for the next edge: surviving entries are copied down in
  // age order, then the new result (if any) is appended behind them. Pop and
  // squash never coincide because a squash only happens when the pipeline
  // owns the write port.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch for the paths that skip it.
    nextEntries = entries;
    wrPos       = '0;
    keepEntry   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      nextEntries[i].valid = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      keepEntry = entries[i].valid
                  && !(popEn && (i == 0))
                  && !(squashEn && (entries[i].regIdx == squashReg));
      if (keepEntry) begin
        nextEntries[wrPos[IDX_W-1:0]] = entries[i];
        wrPos                         = wrPos + 1'b1;
      end
    end
    if (pushEn) begin
      nextEntries[wrPos[IDX_W-1:0]] = '{valid: 1'b1, regIdx: pushReg, data: pushData};
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      // NOTE: only the valid bits are reset; the payload is don't-care until
      // its valid bit is set, so it needs no reset.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      entries <= nextEntries;
    end
  end

  assign headValid = entries[0].valid;
  assign headReg   = entries[0].regIdx;
  assign headData  = entries[0].data;

  always_comb begin
    validCount = '0;
    busyMask   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid) begin
        validCount               = validCount + 1'b1;
        busyMask[entries[i].regIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
// Drives the register file's single write port from two sources: the in-order
// pipeline writeback (never stalls) and out-of-order multiply/divide results,
// which wait in a squashable queue. Also exports the busy mask of queued
// destinations and forwarding data for the two read addresses.
//
// Ports
//   clock, ctrl_reset              : clock, synchronous active-low reset
//   wb_valid/wb_reg/wb_data        : pipeline writeback
//   md_valid/md_ready/md_reg/md_data : multdiv result handshake
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered write port
//   busy_mask                      : registers with a queued multdiv write
//   ctrl_readRegA/B                : regfile read addresses
//   fwd_hitA/B, fwd_dataA/B        : output register forwarding
// ---------------------------------------------------------------------------
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int REG_W  = regfile_pkg::REG_W
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [REG_W-1:0]    md_reg,
  input  logic [DATA_W-1:0]   md_data,
  output logic                ctrl_writeEnable,
  output logic [REG_W-1:0]    ctrl_writeReg,
  output logic [DATA_W-1:0]   data_writeReg,
  output logic [NUM_REGS-1:0] busy_mask,
  input  logic [REG_W-1:0]    ctrl_readRegA,
  input  logic [REG_W-1:0]    ctrl_readRegB,
  output logic                fwd_hitA,
  output logic                fwd_hitB,
  output logic [DATA_W-1:0]   fwd_dataA,
  output logic [DATA_W-1:0]   fwd_dataB
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_FIFO,
    SEL_BYPASS
  } wrSel_t;

  wrSel_t            wrSel;
  logic              pipeWrite;
  logic              mdAccept;
  logic              mdNonZero;
  logic              pushEn;
  logic              popEn;
  logic              headValid;
  logic [REG_W-1:0]  headReg;
  logic [DATA_W-1:0] headData;
  logic [CNT_W-1:0]  validCount;
  logic [REG_W-1:0]  selReg;
  logic [DATA_W-1:0] selData;

  // Writes to the zero register are dropped at the source.
  assign pipeWrite = wb_valid && (wb_reg != REG_W'(ZERO_REG));
  assign mdNonZero = md_reg != REG_W'(ZERO_REG);

  // Readiness depends only on state so the multdiv unit sees no loop through
  // md_valid.
  assign md_ready = ctrl_reset && (validCount < CNT_W'(DEPTH));
  assign mdAccept = md_valid && md_ready;

  // Pipeline first (it cannot stall), then the oldest queued result, then a
  // same-cycle bypass when nothing older is waiting.
  always_comb begin
    wrSel = SEL_NONE;
    if (pipeWrite) begin
      wrSel = SEL_PIPE;
    end else if (headValid) begin
      wrSel = SEL_FIFO;
    end else if (mdAccept && mdNonZero) begin
      wrSel = SEL_BYPASS;
    end
  end

  always_comb begin
    selReg  = '0;
    selData = '0;
    unique case (wrSel)
      SEL_PIPE:   begin selReg = wb_reg;  selData = wb_data;  end
      SEL_FIFO:   begin selReg = headReg; selData = headData; end
      SEL_BYPASS: begin selReg = md_reg;  selData = md_data;  end
      default:    ;
    endcase
  end

  assign popEn  = wrSel == SEL_FIFO;
  assign pushEn = mdAccept && mdNonZero && (wrSel != SEL_BYPASS);

  // A pipeline write is younger than every queued result, so any queued
  // write to the same register is stale and is squashed.
  wb_md_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .pushEn     (pushEn),
    .pushReg    (md_reg),
    .pushData   (md_data),
    .popEn      (popEn),
    .squashEn   (pipeWrite),
    .squashReg  (wb_reg),
    .headValid  (headValid),
    .headReg    (headReg),
    .headData   (headData),
    .validCount (validCount),
    .busyMask   (busy_mask)
  );

  // Index and data hold when idle; only the enable drops.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= wrSel != SEL_NONE;
      if (wrSel != SEL_NONE) begin
        ctrl_writeReg <= selReg;
        data_writeReg <= selData;
      end
    end
  end

  // The output register holds a value the regfile has not committed yet.
  assign fwd_hitA  = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)
                     && (ctrl_readRegA != REG_W'(ZERO_REG));
  assign fwd_hitB  = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)
                     && (ctrl_readRegB != REG_W'(ZERO_REG));
  assign fwd_dataA = fwd_hitA ? data_writeReg : '0;
  assign fwd_dataB = fwd_hitB ? data_writeReg : '0;

endmodule
